// File: rtl/if_id_fetch_queue_if.sv
// Handshake bundle between IF, the fetch queue and ID.
// The queue sits on the slave side; the fetch/decode environment uses master.
interface if_id_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [31:0]       inst_i;
  logic              push_ready_o;
  logic              hd_i;
  logic              flush_i;
  logic              valid_o;
  logic [31:0]       inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [5:0]        op_o;
  logic [4:0]        rs_o;
  logic [4:0]        rt_o;
  logic [4:0]        rd_o;
  logic [15:0]       imm_o;
  logic [25:0]       jaddr_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output push_i, inst_addr_i, inst_i, hd_i, flush_i,
    input  push_ready_o, valid_o, inst_o, inst_addr_o,
    input  op_o, rs_o, rt_o, rd_o, imm_o, jaddr_o, count_o
  );

  modport slave (
    input  push_i, inst_addr_i, inst_i, hd_i, flush_i,
    output push_ready_o, valid_o, inst_o, inst_addr_o,
    output op_o, rs_o, rt_o, rd_o, imm_o, jaddr_o, count_o
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// DEPTH-entry IF/ID instruction queue: circular buffer updated on the falling
// edge, head presented combinationally and pre-split into MIPS fields.
module if_id_fetch_queue #(
  parameter int          ADDR_W = 32,
  parameter int          DEPTH  = 4,
  parameter logic [31:0] BUBBLE = 32'hFC000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_id_fetch_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [31:0]       r_inst_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic        w_valid;
  logic        w_full;
  logic        w_pop;
  logic        w_ready;
  logic        w_push;
  logic [31:0] w_inst;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = w_valid & ~q.hd_i & ~q.flush_i;
  // A full queue still accepts when the head leaves on the same edge.
  assign w_ready = ~q.flush_i & (~w_full | w_pop);
  assign w_push  = q.push_i & w_ready;

  assign w_inst = w_valid ? r_inst_mem[r_rd_ptr] : BUBBLE;

  assign q.push_ready_o = w_ready;
  assign q.valid_o      = w_valid;
  assign q.inst_o       = w_inst;
  assign q.inst_addr_o  = w_valid ? r_addr_mem[r_rd_ptr] : '0;
  assign q.op_o         = w_inst[31:26];
  assign q.rs_o         = w_inst[25:21];
  assign q.rt_o         = w_inst[20:16];
  assign q.rd_o         = w_inst[15:11];
  assign q.imm_o        = w_inst[15:0];
  assign q.jaddr_o      = w_inst[25:0];
  assign q.count_o      = r_count;

  // Slot contents need no reset: only live slots ever reach the outputs.
  always_ff @(negedge clk_i) begin
    if (w_push && !rst_i) begin
      r_inst_mem[r_wr_ptr] <= q.inst_i;
      r_addr_mem[r_wr_ptr] <= q.inst_addr_i;
    end
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (q.flush_i) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for the IF/ID fetch queue (DEPTH=4), checked against
// hand-computed values and a small reference queue for the streaming case.
module tb_if_id_fetch_queue;
  localparam logic [31:0] BUB = 32'hFC000000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  if_id_fetch_queue_if #(.ADDR_W(32), .DEPTH(4)) bus ();

  if_id_fetch_queue #(.ADDR_W(32), .DEPTH(4), .BUBBLE(BUB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .q     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one falling edge, then let outputs settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic push, input logic [31:0] addr, input logic [31:0] inst,
                       input logic hd, input logic flush);
    bus.push_i      = push;
    bus.inst_addr_i = addr;
    bus.inst_i      = inst;
    bus.hd_i        = hd;
    bus.flush_i     = flush;
    #1;
  endtask

  logic [31:0] mdl_addr [$];
  logic [31:0] mdl_inst [$];
  int          sent;
  int          popped;
  logic        exp_pop;
  logic        exp_ready;
  logic        hd;

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h200, 32'h12345678, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_count", bus.count_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_inst", bus.inst_o, BUB);
    check("rst_addr", bus.inst_addr_o, 0);
    check("rst_op", bus.op_o, 6'h3F);
    check("rst_rs", bus.rs_o, 0);
    check("rst_jaddr", bus.jaddr_o, 0);
    check("rst_ready", bus.push_ready_o, 1);
    $display("reset done count=%0d", bus.count_o);

    // First push becomes visible one edge later
    rst = 1'b0;
    drive(1'b1, 32'h100, 32'h8C220004, 1'b1, 1'b0);
    tick();
    check("lw_valid", bus.valid_o, 1);
    check("lw_op", bus.op_o, 6'h23);
    check("lw_rs", bus.rs_o, 1);
    check("lw_rt", bus.rt_o, 2);
    check("lw_rd", bus.rd_o, 0);
    check("lw_imm", bus.imm_o, 16'h0004);
    check("lw_addr", bus.inst_addr_o, 32'h100);
    check("lw_count", bus.count_o, 1);
    $display("push lw addr=%0h op=%0h", bus.inst_addr_o, bus.op_o);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    check("lw_drain", bus.count_o, 0);

    // Stall fill: five offers under hd, the fifth is held back
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'(4 * k), 32'h20000000 | 32'(k), 1'b1, 1'b0);
      check("fill_ready", bus.push_ready_o, (k < 4) ? 1 : 0);
      tick();
      check("fill_count", bus.count_o, (k < 4) ? k + 1 : 4);
      check("fill_head", bus.inst_addr_o, 0);
      $display("fill k=%0d count=%0d ready=%0d", k, bus.count_o, bus.push_ready_o);
    end
    drive(1'b1, 32'h10, 32'h20000004, 1'b0, 1'b0);
    check("release_ready", bus.push_ready_o, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) drive(1'b0, 0, 0, 1'b0, 1'b0);
      check("drain_addr", bus.inst_addr_o, 32'(4 * k));
      check("drain_inst", bus.inst_o, 32'h20000000 | 32'(k));
      check("drain_count", bus.count_o, (k == 1) ? 4 : 5 - k);
      $display("drain addr=%0h count=%0d", bus.inst_addr_o, bus.count_o);
    end
    tick();
    check("drain_empty", bus.count_o, 0);

    // Flush with a simultaneous push drops the push
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hA0 + 32'(4 * k), 32'h00000020, 1'b1, 1'b0);
      tick();
    end
    check("pre_flush_count", bus.count_o, 3);
    drive(1'b1, 32'h20, 32'h11111111, 1'b0, 1'b1);
    check("flush_ready", bus.push_ready_o, 0);
    check("flush_nopop_valid", bus.valid_o, 1);
    tick();
    check("flush_count", bus.count_o, 0);
    check("flush_valid", bus.valid_o, 0);
    check("flush_inst", bus.inst_o, BUB);
    check("flush_addr", bus.inst_addr_o, 0);
    drive(1'b1, 32'h40, 32'h08000010, 1'b0, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    check("after_flush_count", bus.count_o, 1);
    check("after_flush_addr", bus.inst_addr_o, 32'h40);
    check("after_flush_jaddr", bus.jaddr_o, 26'h10);
    $display("flush+push addr=%0h count=%0d", bus.inst_addr_o, bus.count_o);
    tick();
    check("after_flush_empty", bus.count_o, 0);

    // Flush wins over a stall
    drive(1'b1, 32'h50, 32'h01000000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h54, 32'h02000000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    tick();
    check("flush_hd_count", bus.count_o, 0);
    check("flush_hd_valid", bus.valid_o, 0);
    check("flush_hd_op", bus.op_o, 6'h3F);
    $display("flush vs stall count=%0d", bus.count_o);
    drive(1'b0, 0, 0, 1'b0, 1'b0);

    // Wrap-around stream with alternating stall against a reference queue
    sent = 0;
    popped = 0;
    for (int cyc = 0; cyc < 80 && (sent < 12 || mdl_addr.size() > 0); cyc++) begin
      hd = cyc[0];
      drive(sent < 12, 32'h1000 + 32'(4 * sent), 32'hA5000000 + 32'(sent), hd, 1'b0);
      exp_pop   = (mdl_addr.size() > 0) && !hd;
      exp_ready = (mdl_addr.size() < 4) || exp_pop;
      check("wrap_ready", bus.push_ready_o, exp_ready);
      check("wrap_valid", bus.valid_o, mdl_addr.size() > 0);
      if (mdl_addr.size() > 0) begin
        check("wrap_head_addr", bus.inst_addr_o, mdl_addr[0]);
        check("wrap_head_inst", bus.inst_o, mdl_inst[0]);
      end
      if (exp_pop) begin
        $display("wrap pop addr=%0h", mdl_addr[0]);
        void'(mdl_addr.pop_front());
        void'(mdl_inst.pop_front());
        popped++;
      end
      if (sent < 12 && exp_ready) begin
        mdl_addr.push_back(32'h1000 + 32'(4 * sent));
        mdl_inst.push_back(32'hA5000000 + 32'(sent));
        sent++;
      end
      tick();
      check("wrap_count", bus.count_o, mdl_addr.size());
    end
    check("wrap_popped", popped, 12);
    check("wrap_empty", bus.count_o, 0);

    // Empty-queue throughput: each entry visible exactly one edge after push
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k), 32'h3C000000 + 32'(k), 1'b0, 1'b0);
      tick();
      check("thru_count", bus.count_o, 1);
      check("thru_addr", bus.inst_addr_o, 32'h300 + 32'(4 * k));
      $display("thru addr=%0h count=%0d", bus.inst_addr_o, bus.count_o);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    check("thru_empty", bus.count_o, 0);

    // Reset mid-stream discards entries
    drive(1'b1, 32'h700, 32'h01234567, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    check("mid_rst_count", bus.count_o, 0);
    check("mid_rst_inst", bus.inst_o, BUB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
